// File: rtl/repeat_emitter.sv
// Parses "<decimal count><payload byte>" from a byte stream and emits the payload count times.
// Define REPEAT_EMITTER_NEWLINE_EN to append one 0x0A to every run, including count-0 runs.
module repeat_emitter #(
    parameter int COUNT_W    = 16,
    parameter int GAP_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       input_valid,
    input  logic [7:0] input_data,
    input  logic       output_busy,
    output logic       output_en,
    output logic [7:0] output_data,
    output logic       run_active,
    output logic       run_done
);

    localparam int                 EXT_W     = COUNT_W + 4;
    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;
    localparam logic [3:0]         GAP_LOAD  = 4'(GAP_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        PARSE,
        EMIT,
        EMIT_GAP
`ifdef REPEAT_EMITTER_NEWLINE_EN
        , TERM
`endif
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [COUNT_W-1:0] count;
    logic [3:0]         gap_cnt;
    logic [7:0]         payload;
    logic               have_digit;

    logic               is_digit;
    logic               is_eol;
    logic [3:0]         digit;
    logic [EXT_W-1:0]   count_ext;
    logic [EXT_W-1:0]   count_mac;
    logic [COUNT_W-1:0] count_sat;
    logic               emit_fire;

    // ASCII '0'..'9' are 0x30..0x39, so the low nibble is already the digit value.
    assign digit     = input_data[3:0];
    assign is_digit  = (input_data[7:4] == 4'h3) && (input_data[3:0] <= 4'd9);
    assign is_eol    = (input_data == 8'h0A) || (input_data == 8'h0D);

    // count*10 + d never overflows the widened sum, so one compare saturates it.
    assign count_ext = {4'b0000, count};
    assign count_mac = (count_ext << 3) + (count_ext << 1) + {{(EXT_W-4){1'b0}}, digit};
    assign count_sat = (|count_mac[EXT_W-1:COUNT_W]) ? COUNT_MAX : count_mac[COUNT_W-1:0];

    assign emit_fire = (state == EMIT) && (count != '0) && !output_busy;

`ifdef REPEAT_EMITTER_NEWLINE_EN
    logic term_sent;
    logic term_fire;
    logic term_exit;
    assign term_fire = (state == TERM) && !term_sent && !output_busy;
    assign term_exit = (state == TERM) && term_sent && (gap_cnt == 4'd0) && !output_busy;
`endif

    // NOTE: sequential state is written only with non-blocking assignments.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= '0;
            gap_cnt    <= 4'd0;
            payload    <= 8'h00;
            have_digit <= 1'b0;
`ifdef REPEAT_EMITTER_NEWLINE_EN
            term_sent  <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
`ifdef REPEAT_EMITTER_NEWLINE_EN
                    term_sent <= 1'b0;
`endif
                    if (input_valid && is_digit) begin
                        count      <= COUNT_W'(digit);
                        have_digit <= 1'b1;
                    end
                end
                PARSE: begin
                    if (input_valid) begin
                        if (is_digit) begin
                            count <= count_sat;
                        end else if (is_eol) begin
                            count      <= '0;
                            have_digit <= 1'b0;
                        end else if (have_digit) begin
                            payload    <= input_data;
                            have_digit <= 1'b0;
                        end
                    end
                end
                EMIT: begin
                    if (emit_fire) begin
                        count   <= count - COUNT_W'(1);
                        gap_cnt <= GAP_LOAD;
                    end
                end
                EMIT_GAP: begin
                    if (gap_cnt != 4'd0) gap_cnt <= gap_cnt - 4'd1;
                end
`ifdef REPEAT_EMITTER_NEWLINE_EN
                TERM: begin
                    if (term_fire) begin
                        term_sent <= 1'b1;
                        gap_cnt   <= GAP_LOAD;
                    end else if (gap_cnt != 4'd0) begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (input_valid && is_digit) state_next = PARSE;
            end
            PARSE: begin
                if (input_valid) begin
                    if (is_eol) begin
                        state_next = IDLE;
                    end else if (!is_digit && have_digit) begin
                        state_next = EMIT;
                    end
                end
            end
            EMIT: begin
                if (count == '0) begin
`ifdef REPEAT_EMITTER_NEWLINE_EN
                    state_next = TERM;
`else
                    state_next = IDLE;
`endif
                end else if (!output_busy) begin
                    state_next = EMIT_GAP;
                end
            end
            EMIT_GAP: begin
                // The decrement to zero happens this cycle, so leave on the last gap cycle.
                if ((gap_cnt <= 4'd1) && !output_busy) state_next = EMIT;
            end
`ifdef REPEAT_EMITTER_NEWLINE_EN
            TERM: begin
                if (term_exit) state_next = IDLE;
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        output_en   = emit_fire;
        output_data = payload;
        run_active  = (state == EMIT) || (state == EMIT_GAP);
`ifdef REPEAT_EMITTER_NEWLINE_EN
        run_done    = term_exit;
        if (state == TERM) begin
            output_en   = term_fire;
            output_data = 8'h0A;
            run_active  = 1'b1;
        end
`else
        run_done    = (state == EMIT) && (count == '0);
`endif
    end

endmodule

// File: tb/tb_repeat_emitter.sv
// Directed bench for repeat_emitter: parsing, saturation, aborts, busy handling, mid-run reset.
// Also builds with REPEAT_EMITTER_NEWLINE_EN to check the trailing 0x0A.
module tb_repeat_emitter;

`ifdef REPEAT_EMITTER_NEWLINE_EN
    localparam int NL = 1;
`else
    localparam int NL = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       input_valid;
    logic [7:0] input_data;
    logic       output_busy = 1'b0;
    logic       output_en;
    logic [7:0] output_data;
    logic       run_active;
    logic       run_done;

    repeat_emitter #(.COUNT_W(16), .GAP_CYCLES(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .input_valid (input_valid),
        .input_data  (input_data),
        .output_busy (output_busy),
        .output_en   (output_en),
        .output_data (output_data),
        .run_active  (run_active),
        .run_done    (run_done)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    int cyc = 0;
    int pulse_cnt, done_cnt, nl_cnt, data_bad, busy_viol, active_low;
    int last_in_cyc, done_cyc;
    int pulse_cyc [16];
    logic [7:0] pulse_data [16];
    logic [7:0] exp_data;
    logic track_active = 1'b0;
    logic en_seen = 1'b0;
    logic busy_mode = 1'b0;
    int busy_left = 0;

    // Monitor samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        cyc++;
        en_seen = output_en;
        if (input_valid) last_in_cyc = cyc;
        if (track_active && !run_active) active_low++;
        if (output_en) begin
            if (pulse_cnt < 16) begin
                pulse_data[pulse_cnt] = output_data;
                pulse_cyc[pulse_cnt]  = cyc;
            end
            pulse_cnt++;
            if (output_data == 8'h0A) nl_cnt++;
            else if (output_data !== exp_data) data_bad++;
            if (output_busy) busy_viol++;
        end
        if (run_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    // Transmitter model: busy for 5 cycles after each accepted byte when enabled.
    always @(posedge clk) begin
        #1;
        if (busy_mode && en_seen) busy_left = 5;
        else if (busy_left > 0) busy_left--;
        output_busy = busy_mode && (busy_left > 0);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic clear_mon();
        pulse_cnt  = 0;
        done_cnt   = 0;
        nl_cnt     = 0;
        data_bad   = 0;
        busy_viol  = 0;
        active_low = 0;
        done_cyc   = 0;
        for (int i = 0; i < 16; i++) begin
            pulse_cyc[i]  = 0;
            pulse_data[i] = 8'h00;
        end
    endtask

    // Called at posedge+1; returns at the next posedge+1.
    task automatic send_byte(input logic [7:0] b);
        input_valid = 1'b1;
        input_data  = b;
        @(posedge clk); #1;
        input_valid = 1'b0;
        input_data  = 8'h00;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_done(input int target, input int budget, input string tag);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_done_in_time"}, 32'(done_cnt >= target), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        input_valid = 1'b0;
        input_data  = 8'h00;
        exp_data    = 8'h00;
        clear_mon();
        last_in_cyc = 0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_output_en",   32'(output_en),   32'd0);
        check("rst_output_data", 32'(output_data), 32'h00);
        check("rst_run_active",  32'(run_active),  32'd0);
        check("rst_run_done",    32'(run_done),    32'd0);
        rst = 1'b0;
        idle_cycles(2);

        // "3x" with busy tied low
        clear_mon();
        exp_data = 8'h78;
        send_byte("3");
        send_byte("x");
        check("a_run_active_mid", 32'(run_active), 32'd1);
        wait_done(1, 30, "a");
        check("a_pulses",     32'(pulse_cnt), 32'(3 + NL));
        check("a_data_bad",   32'(data_bad),  32'd0);
        check("a_third_data", 32'(pulse_data[2]), 32'h78);
        check("a_latency",    32'(pulse_cyc[0] - last_in_cyc), 32'd1);
        check("a_spacing_01", 32'(pulse_cyc[1] - pulse_cyc[0]), 32'd2);
        check("a_spacing_12", 32'(pulse_cyc[2] - pulse_cyc[1]), 32'd2);
        check("a_done_after_gap", 32'(done_cyc - pulse_cyc[2 + NL]), 32'd2);
        idle_cycles(3);
        check("a_done_once",    32'(done_cnt),    32'd1);
        check("a_idle_active",  32'(run_active),  32'd0);
        check("a_data_holds",   32'(output_data), 32'h78);

        // "12#" with a transmitter that stays busy 5 cycles per byte
        clear_mon();
        exp_data  = 8'h23;
        busy_mode = 1'b1;
        send_byte("1");
        send_byte("2");
        send_byte("#");
        track_active = 1'b1;
        wait_done(1, 300, "b");
        track_active = 1'b0;
        check("b_pulses",     32'(pulse_cnt),  32'(12 + NL));
        check("b_data_bad",   32'(data_bad),   32'd0);
        check("b_busy_viol",  32'(busy_viol),  32'd0);
        check("b_active_low", 32'(active_low), 32'd0);
        busy_mode = 1'b0;
        idle_cycles(8);
        check("b_done_once",  32'(done_cnt),   32'd1);

        // "99999z": saturation, then reset in the middle of the run
        clear_mon();
        exp_data = 8'h7A;
        repeat (4) send_byte("9");
        check("c_count_9999", 32'(dut.count), 32'd9999);
        send_byte("9");
        check("c_count_sat",  32'(dut.count), 32'd65535);
        send_byte("z");
        begin
            int n = 0;
            while (pulse_cnt < 3 && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
        end
        check("c_three_pulses", 32'(pulse_cnt), 32'd3);
        check("c_count_after3", 32'(dut.count), 32'd65532);
        check("c_data_bad",     32'(data_bad),  32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("c_rst_output_en",  32'(output_en),   32'd0);
        check("c_rst_run_active", 32'(run_active),  32'd0);
        check("c_rst_output_data", 32'(output_data), 32'h00);
        rst = 1'b0;
        idle_cycles(20);
        check("c_no_more_pulses", 32'(pulse_cnt), 32'd3);
        check("c_no_run_done",    32'(done_cnt),  32'd0);

        // "0q": empty run
        clear_mon();
        exp_data = 8'h71;
        send_byte("0");
        send_byte("q");
        wait_done(1, 20, "d");
        idle_cycles(5);
        check("d_pulses",    32'(pulse_cnt), 32'(NL));
        check("d_done_once", 32'(done_cnt),  32'd1);
`ifdef REPEAT_EMITTER_NEWLINE_EN
        check("d_newline", 32'(nl_cnt), 32'd1);
`endif

        // Stray byte, LF and CR aborts, then "2b" with bytes injected mid-run
        clear_mon();
        exp_data = 8'h62;
        send_byte("z");
        send_byte("4");
        send_byte(8'h0A);
        send_byte("7");
        send_byte(8'h0D);
        idle_cycles(4);
        check("e_abort_pulses", 32'(pulse_cnt),  32'd0);
        check("e_abort_done",   32'(done_cnt),   32'd0);
        check("e_abort_active", 32'(run_active), 32'd0);
        send_byte("2");
        send_byte("b");
        send_byte("5");
        send_byte("c");
        wait_done(1, 30, "e");
        idle_cycles(10);
        check("e_pulses",    32'(pulse_cnt), 32'(2 + NL));
        check("e_data_bad",  32'(data_bad),  32'd0);
        check("e_done_once", 32'(done_cnt),  32'd1);

`ifdef REPEAT_EMITTER_NEWLINE_EN
        // "2k": payload twice, then the newline, then run_done
        clear_mon();
        exp_data = 8'h6B;
        send_byte("2");
        send_byte("k");
        wait_done(1, 30, "f");
        check("f_pulses", 32'(pulse_cnt),     32'd3);
        check("f_byte0",  32'(pulse_data[0]), 32'h6B);
        check("f_byte1",  32'(pulse_data[1]), 32'h6B);
        check("f_byte2",  32'(pulse_data[2]), 32'h0A);
        check("f_done_after_nl", 32'(done_cyc - pulse_cyc[2]), 32'd2);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/repeat_emitter.md
Name: repeat_emitter

Overview:
- Byte-stream command block between the UART receiver and the UART transmitter.
- Parses a multi-digit decimal repeat count followed by a payload character, e.g. "12x" or "300#".
- Emits the payload character on the transmit interface count times, one byte per transmitter handshake.
- Generalises the single-digit, fixed-'A' emitter: parametrised count width, saturating arithmetic, arbitrary payload, abort handling, status outputs.

Parameters:
COUNT_W, 16, width of the repeat counter; parsed counts saturate at 2^COUNT_W-1.
GAP_CYCLES, 1, minimum cycles after an output_en pulse before output_busy is sampled again (range 1..15).

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
input_valid  input  1  one-cycle strobe, input_data valid
input_data  input  8  received byte
output_busy  input  1  transmitter busy with the previous byte
output_en  output  1  one-cycle strobe, send output_data
output_data  output  8  byte to transmit
run_active  output  1  high while in EMIT, EMIT_GAP or TERM
run_done  output  1  one-cycle pulse on return to IDLE after a completed run, including count 0

Behaviour:
- Reset values: output_en=0, output_data=0, run_active=0, run_done=0, count=0, have_digit=0, state=IDLE. Reset overrides everything, mid-run included; any pending emission is discarded.
- States: IDLE, PARSE, EMIT, EMIT_GAP, TERM.
- output_en and run_done default to 0 every cycle and are asserted only for the single cycle described below.
- IDLE, on input_valid:
  - digit '0'..'9': count <= digit value, have_digit=1, go to PARSE.
  - any other byte: ignored.
- PARSE, on input_valid:
  - digit: count <= min(count*10 + d, 2^COUNT_W-1). Compute in COUNT_W+4 bits and saturate once saturated; the value stays at max.
  - 0x0A or 0x0D: abort. count <= 0, go to IDLE, no output, no run_done.
  - any other byte: latch it as payload into output_data, go to EMIT.
- EMIT:
  - If count==0: go to IDLE (TERM when NEWLINE_EN is defined) with no byte sent.
  - Else, when !output_busy: output_en=1, count <= count-1, load gap counter with GAP_CYCLES, go to EMIT_GAP.
  - While output_busy=1: hold, no pulse.
- EMIT_GAP:
  - Decrement the gap counter. When it reaches 0 and output_busy=0, go to EMIT.
  - output_busy seen during the gap does not shorten it.
- Run completion: when EMIT finds count==0 it pulses run_done and goes to IDLE (or TERM).
- Inputs: input_valid during EMIT, EMIT_GAP or TERM is dropped silently; there is no buffering.
- output_data is stable from the payload latch until the next payload latch.
- Latency: first output_en no earlier than 1 cycle after the payload byte strobe, provided output_busy=0.
- Throughput: at most one byte per GAP_CYCLES+1 cycles.

Optional Feature:
- Macro: REPEAT_EMITTER_NEWLINE_EN.
- Defined: after the last payload byte, TERM waits for !output_busy, drives output_data=0x0A with one output_en pulse, observes the same GAP_CYCLES gap and busy wait, then pulses run_done and goes to IDLE. A count of 0 still emits the single 0x0A.
- Undefined: the TERM state is absent; EMIT goes straight to IDLE with run_done.

Test Plan:
- "3x", output_busy tied 0 → exactly 3 output_en pulses with output_data=0x78, 2 cycles apart (GAP_CYCLES=1), then run_done one cycle after the last pulse's gap ends.
- "12#", busy model asserts busy for 5 cycles after each pulse → 12 pulses of 0x23, none while busy=1, run_active high throughout.
- "99999z" with COUNT_W=16 → count saturates at 65535; check the counter value and the first pulses, then reset mid-run → output_en=0 and run_active=0 on the next cycle, with no further pulses.
- "0q" → no output_en; run_done pulses once. With NEWLINE_EN: exactly one 0x0A pulse, then run_done.
- "4" then 0x0A, then "2b" → the abort yields nothing; then 2 pulses of 0x62. Bytes "5c" injected during emission are ignored, so the total is exactly 2 pulses.
- With NEWLINE_EN, "2k" → pulses 0x6B, 0x6B, 0x0A in order, then run_done.
